// File: rtl/turn_signal_monitor.sv
// turn_signal_monitor
// Lamp-side checker for the turn-signal sequencer. Decodes the left/right
// lamp buses into direction and step, polices sweep order and per-step
// dwell, counts completed sweeps and drives one active-low status digit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | both buses dark, waiting for the first step of a sweep
// L1    | left sweep, one lamp lit (001)
// L2    | left sweep, two lamps lit (011)
// L3    | left sweep, three lamps lit (111)
// R1    | right sweep, one lamp lit (100)
// R2    | right sweep, two lamps lit (110)
// R3    | right sweep, three lamps lit (111)
// FLT   | illegal pattern seen, waiting for both buses to go dark

module turn_signal_monitor #(
    parameter int MIN_DWELL = 3,
    parameter int MAX_DWELL = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] leftLight,
    input  logic [2:0] rightLight,
    input  logic       clearFault,
    output logic [1:0] dir,
    output logic [1:0] step,
    output logic       fault,
    output logic [2:0] faultCode,
    output logic [7:0] sweepCount,
    output logic [6:0] HEX3
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        FLT  = 3'd7
    } state_t;

    localparam logic [7:0] MIN_D = 8'(MIN_DWELL);
    localparam logic [7:0] MAX_D = 8'(MAX_DWELL);

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d, dwell_inc;
    logic [2:0] code_det;
    logic       sweep_inc;
    logic       fault_d;
    logic [2:0] code_d;
    logic [1:0] dir_d, step_d;
    logic [6:0] hex_d;

    logic       left_legal, right_legal, both_zero;
    logic       is_left, side_ok, at_top;
    logic [2:0] bus, hold_pat, adv_pat;
    state_t     adv_state;

    // Bus legality and the pattern expectations of the current lit step
    always_comb begin
        left_legal  = (leftLight == 3'b000) || (leftLight == 3'b001) ||
                      (leftLight == 3'b011) || (leftLight == 3'b111);
        right_legal = (rightLight == 3'b000) || (rightLight == 3'b100) ||
                      (rightLight == 3'b110) || (rightLight == 3'b111);
        both_zero   = (leftLight == 3'b000) && (rightLight == 3'b000);
        is_left     = (state_q == L1) || (state_q == L2) || (state_q == L3);
        side_ok     = is_left ? (rightLight == 3'b000) : (leftLight == 3'b000);
        bus         = is_left ? leftLight : rightLight;
        at_top      = (state_q == L3) || (state_q == R3);
        hold_pat    = 3'b000;
        adv_pat     = 3'b000;
        adv_state   = IDLE;
        case (state_q)
            L1: begin hold_pat = 3'b001; adv_pat = 3'b011; adv_state = L2; end
            L2: begin hold_pat = 3'b011; adv_pat = 3'b111; adv_state = L3; end
            L3: begin hold_pat = 3'b111; end
            R1: begin hold_pat = 3'b100; adv_pat = 3'b110; adv_state = R2; end
            R2: begin hold_pat = 3'b110; adv_pat = 3'b111; adv_state = R3; end
            R3: begin hold_pat = 3'b111; end
            default: ;
        endcase
    end

    // Next state, dwell counter and fault detection in priority order
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        code_det  = 3'd0;
        sweep_inc = 1'b0;
        dwell_inc = (dwell_q == 8'd255) ? dwell_q : dwell_q + 8'd1;

        if (state_q == FLT) begin
            dwell_d = 8'd0;
            if (both_zero) begin
                state_d = IDLE;
            end
        end else if ((leftLight != 3'b000) && (rightLight != 3'b000)) begin
            code_det = 3'd1;
        end else if (!left_legal || !right_legal) begin
            code_det = 3'd2;
        end else if (both_zero) begin
            state_d   = IDLE;
            dwell_d   = 8'd0;
            sweep_inc = at_top;
        end else if (state_q == IDLE) begin
            if (leftLight == 3'b001) begin
                state_d = L1;
                dwell_d = 8'd1;
            end else if (rightLight == 3'b100) begin
                state_d = R1;
                dwell_d = 8'd1;
            end else begin
                code_det = 3'd3;
            end
        end else if (!side_ok) begin
            code_det = 3'd3;
        end else if (bus == hold_pat) begin
            if (dwell_q >= MAX_D) begin
                code_det = 3'd5;
            end else begin
                dwell_d = dwell_inc;
            end
        end else if (!at_top && (bus == adv_pat)) begin
            if (dwell_q < MIN_D) begin
                code_det = 3'd4;
            end else begin
                state_d = adv_state;
                dwell_d = 8'd1;
            end
        end else begin
            code_det = 3'd3;
        end

        if (code_det != 3'd0) begin
            state_d   = FLT;
            dwell_d   = 8'd0;
            sweep_inc = 1'b0;
        end
    end

    // Sticky fault: first code wins, but a fault coinciding with a clear relatches
    always_comb begin
        fault_d = fault;
        code_d  = faultCode;
        if (code_det != 3'd0) begin
            fault_d = 1'b1;
            if (!fault || clearFault) begin
                code_d = code_det;
            end
        end else if (clearFault) begin
            fault_d = 1'b0;
            code_d  = 3'd0;
        end
    end

    // Output decode from the next state so outputs track the state register
    always_comb begin
        dir_d  = 2'b00;
        step_d = 2'd0;
        case (state_d)
            L1: begin dir_d = 2'b01; step_d = 2'd1; end
            L2: begin dir_d = 2'b01; step_d = 2'd2; end
            L3: begin dir_d = 2'b01; step_d = 2'd3; end
            R1: begin dir_d = 2'b10; step_d = 2'd1; end
            R2: begin dir_d = 2'b10; step_d = 2'd2; end
            R3: begin dir_d = 2'b10; step_d = 2'd3; end
            default: ;
        endcase
        if (fault_d) begin
            hex_d = SEG_E;
        end else begin
            case (step_d)
                2'd1:    hex_d = SEG_1;
                2'd2:    hex_d = SEG_2;
                2'd3:    hex_d = SEG_3;
                default: hex_d = SEG_BLANK;
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dwell_q    <= 8'd0;
            fault      <= 1'b0;
            faultCode  <= 3'd0;
            sweepCount <= 8'd0;
            dir        <= 2'b00;
            step       <= 2'd0;
            HEX3       <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            fault      <= fault_d;
            faultCode  <= code_d;
            sweepCount <= sweep_inc ? sweepCount + 8'd1 : sweepCount;
            dir        <= dir_d;
            step       <= step_d;
            HEX3       <= hex_d;
        end
    end

endmodule

// File: tb/tb_turn_signal_monitor.sv
// Testbench for turn_signal_monitor: directed scenarios plus random sweeps,
// all checked against a level-based behavioural model of the lamp rules.

module tb_turn_signal_monitor;

    localparam int MIN_DWELL = 3;
    localparam int MAX_DWELL = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] leftLight, rightLight;
    logic       clearFault;
    logic [1:0] dir, step;
    logic       fault;
    logic [2:0] faultCode;
    logic [7:0] sweepCount;
    logic [6:0] HEX3;

    int n_vec = 0;
    int n_err = 0;

    turn_signal_monitor #(.MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .leftLight(leftLight), .rightLight(rightLight),
        .clearFault(clearFault), .dir(dir), .step(step), .fault(fault),
        .faultCode(faultCode), .sweepCount(sweepCount), .HEX3(HEX3)
    );

    always #5 clk = ~clk;

    wire [22:0] dut_out = {dir, step, fault, faultCode, sweepCount, HEX3};

    // Model: side 0 idle, 1 left, 2 right, 3 faulted; lvl = lamps lit
    int m_side, m_lvl, m_dwell, m_code, m_sweeps;
    bit m_fault;

    function automatic logic [2:0] pat(input int side, input int lvl);
        int v;
        if (side == 1) v = (1 << lvl) - 1;
        else           v = (7 << (3 - lvl)) & 7;
        return 3'(v);
    endfunction

    function automatic int level_of(input logic [2:0] b, input int side);
        int n;
        n = $countones(b);
        return (b == pat(side, n)) ? n : -1;
    endfunction

    function automatic void model_reset();
        m_side = 0; m_lvl = 0; m_dwell = 0; m_code = 0; m_sweeps = 0; m_fault = 0;
    endfunction

    function automatic void model_step(input logic [2:0] l, input logic [2:0] r, input logic c);
        int ll, rl, a, lev, code;
        ll = level_of(l, 1);
        rl = level_of(r, 2);
        code = 0;
        if (m_side == 3) begin
            if (l == 0 && r == 0) begin m_side = 0; m_lvl = 0; end
        end else if (l != 0 && r != 0) begin
            code = 1;
        end else if (ll < 0 || rl < 0) begin
            code = 2;
        end else begin
            a   = (l != 0) ? 1 : ((r != 0) ? 2 : 0);
            lev = (a == 1) ? ll : rl;
            if (a == 0) begin
                if (m_side != 0 && m_lvl == 3) m_sweeps = (m_sweeps + 1) % 256;
                m_side = 0; m_lvl = 0; m_dwell = 0;
            end else if (m_side == 0) begin
                if (lev == 1) begin m_side = a; m_lvl = 1; m_dwell = 1; end
                else code = 3;
            end else if (a != m_side) begin
                code = 3;
            end else if (lev == m_lvl) begin
                if (m_dwell + 1 > MAX_DWELL) code = 5;
                else m_dwell = (m_dwell + 1 > 255) ? 255 : m_dwell + 1;
            end else if (lev == m_lvl + 1) begin
                if (m_dwell < MIN_DWELL) code = 4;
                else begin m_lvl = lev; m_dwell = 1; end
            end else begin
                code = 3;
            end
        end
        if (code != 0) begin
            m_side = 3; m_lvl = 0; m_dwell = 0;
            if (!m_fault || c) m_code = code;
            m_fault = 1;
        end else if (c) begin
            m_fault = 0; m_code = 0;
        end
    endfunction

    function automatic logic [22:0] model_out();
        logic [1:0] d, s;
        logic [6:0] h;
        d = (m_side == 1) ? 2'b01 : ((m_side == 2) ? 2'b10 : 2'b00);
        s = (m_side == 1 || m_side == 2) ? 2'(m_lvl) : 2'd0;
        if (m_fault) h = 7'b0000110;
        else case (s)
            2'd1:    h = 7'b1111001;
            2'd2:    h = 7'b0100100;
            2'd3:    h = 7'b0110000;
            default: h = 7'b1111111;
        endcase
        return {d, s, m_fault, 3'(m_code), 8'(m_sweeps), h};
    endfunction

    // One clock of stimulus; the model advances on the same edge
    task automatic cyc(input logic [2:0] l, input logic [2:0] r, input logic c);
        leftLight = l; rightLight = r; clearFault = c;
        @(posedge clk);
        model_step(l, r, c);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; leftLight = 0; rightLight = 0; clearFault = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (dut_out !== {16'h0, 7'b1111111}) begin
            n_err++; $display("FAIL reset got %h expected %h", dut_out, {16'h0, 7'b1111111});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_left_sweep();
        logic [6:0] hexes [4];
        int k;
        hexes[0] = 7'b1111001; hexes[1] = 7'b0100100; hexes[2] = 7'b0110000; hexes[3] = 7'b1111111;
        k = 0;
        for (int lv = 1; lv <= 4; lv++) begin
            for (int i = 0; i < ((lv == 4) ? 1 : 3); i++) begin
                cyc((lv == 4) ? 3'b000 : pat(1, lv), 3'b000, 1'b0);
                n_vec++;
                if (dut_out !== model_out()) begin
                    n_err++; $display("FAIL left_sweep cyc %0d got %h expected %h", k, dut_out, model_out());
                end
                if (i == 0) begin
                    n_vec++;
                    if (HEX3 !== hexes[lv-1] || step !== 2'((lv == 4) ? 0 : lv)) begin
                        n_err++; $display("FAIL left_sweep_hex lvl %0d got %b/%0d expected %b", lv, HEX3, step, hexes[lv-1]);
                    end
                end
                k++;
            end
        end
        n_vec++;
        if (sweepCount !== 8'd1 || fault !== 1'b0) begin
            n_err++; $display("FAIL left_sweep_count got %0d/%b expected 1/0", sweepCount, fault);
        end
    endtask

    task automatic test_right_cancel();
        logic [2:0] seq [7];
        seq = '{3'b100, 3'b100, 3'b100, 3'b110, 3'b110, 3'b110, 3'b000};
        for (int i = 0; i < 7; i++) begin
            cyc(3'b000, seq[i], 1'b0);
            n_vec++;
            if (dut_out !== model_out()) begin
                n_err++; $display("FAIL right_cancel cyc %0d got %h expected %h", i, dut_out, model_out());
            end
        end
        n_vec++;
        if (sweepCount !== 8'd1 || step !== 2'd0 || fault !== 1'b0) begin
            n_err++; $display("FAIL right_cancel_end got %0d/%0d/%b expected 1/0/0", sweepCount, step, fault);
        end
    endtask

    task automatic test_skip();
        repeat (3) cyc(3'b001, 3'b000, 1'b0);
        cyc(3'b111, 3'b000, 1'b0);
        n_vec++;
        if (fault !== 1'b1 || faultCode !== 3'd3 || HEX3 !== 7'b0000110 || dut_out !== model_out()) begin
            n_err++; $display("FAIL skip got %b/%0d/%b expected 1/3/0000110", fault, faultCode, HEX3);
        end
        cyc(3'b000, 3'b000, 1'b0);
        n_vec++;
        if (fault !== 1'b1 || dut_out !== model_out()) begin
            n_err++; $display("FAIL skip_idle got %h expected %h", dut_out, model_out());
        end
        cyc(3'b000, 3'b000, 1'b1);
        cyc(3'b000, 3'b000, 1'b0);
        n_vec++;
        if (fault !== 1'b0 || HEX3 !== 7'b1111111 || dut_out !== model_out()) begin
            n_err++; $display("FAIL skip_clear got %b/%b expected 0/1111111", fault, HEX3);
        end
    endtask

    task automatic test_timing();
        repeat (2) cyc(3'b000, 3'b100, 1'b0);
        cyc(3'b000, 3'b110, 1'b0);
        n_vec++;
        if (faultCode !== 3'd4 || dut_out !== model_out()) begin
            n_err++; $display("FAIL early_advance got code %0d expected 4", faultCode);
        end
        cyc(3'b000, 3'b000, 1'b1);
        cyc(3'b000, 3'b000, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            cyc(3'b001, 3'b000, 1'b0);
            n_vec++;
            if (fault !== ((i == 17) ? 1'b1 : 1'b0) || dut_out !== model_out()) begin
                n_err++; $display("FAIL dwell_hold cyc %0d got %h expected %h", i, dut_out, model_out());
            end
        end
        n_vec++;
        if (faultCode !== 3'd5) begin
            n_err++; $display("FAIL dwell_max got code %0d expected 5", faultCode);
        end
        cyc(3'b000, 3'b000, 1'b1);
    endtask

    task automatic test_conflicts();
        cyc(3'b001, 3'b100, 1'b0);
        n_vec++;
        if (faultCode !== 3'd1 || dut_out !== model_out()) begin
            n_err++; $display("FAIL both_lit got code %0d expected 1", faultCode);
        end
        cyc(3'b000, 3'b000, 1'b1);
        cyc(3'b010, 3'b000, 1'b0);
        n_vec++;
        if (faultCode !== 3'd2 || dut_out !== model_out()) begin
            n_err++; $display("FAIL illegal got code %0d expected 2", faultCode);
        end
        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b001, 3'b100, 1'b0);
        n_vec++;
        if (faultCode !== 3'd2 || fault !== 1'b1 || dut_out !== model_out()) begin
            n_err++; $display("FAIL first_wins got code %0d expected 2", faultCode);
        end
        cyc(3'b000, 3'b000, 1'b0);
        cyc(3'b111, 3'b000, 1'b1);
        n_vec++;
        if (faultCode !== 3'd3 || fault !== 1'b1 || dut_out !== model_out()) begin
            n_err++; $display("FAIL clear_vs_fault got %b/%0d expected 1/3", fault, faultCode);
        end
        cyc(3'b000, 3'b000, 1'b1);
    endtask

    task automatic test_wrap();
        logic [2:0] q [$];
        rst_n = 1'b0; #2; rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < 256; s++) begin
            for (int lv = 1; lv <= 3; lv++) repeat (3) q.push_back(pat(1 + (s % 2), lv));
            q.push_back(3'b000);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (((i / 10) % 2) == 0) cyc(q[i], 3'b000, 1'b0);
            else                     cyc(3'b000, q[i], 1'b0);
            n_vec++;
            if (dut_out !== model_out()) begin
                n_err++; $display("FAIL wrap cyc %0d got %h expected %h", i, dut_out, model_out());
            end
            if (i == 2549) begin
                n_vec++;
                if (sweepCount !== 8'd255) begin
                    n_err++; $display("FAIL wrap_255 got %0d expected 255", sweepCount);
                end
            end
        end
        n_vec++;
        if (sweepCount !== 8'd0) begin
            n_err++; $display("FAIL wrap_0 got %0d expected 0", sweepCount);
        end
    endtask

    task automatic test_random();
        logic [6:0] q [$];
        int side, hold;
        for (int it = 0; it < 200; it++) begin
            side = $urandom_range(1, 2);
            for (int lv = 1; lv <= 3; lv++) begin
                hold = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 18) : $urandom_range(3, 5);
                repeat (hold) begin
                    if (side == 1) q.push_back({pat(1, lv), 3'b000, 1'($urandom_range(0, 15) == 0)});
                    else           q.push_back({3'b000, pat(2, lv), 1'($urandom_range(0, 15) == 0)});
                end
                if ($urandom_range(0, 9) == 0) break;
            end
            if ($urandom_range(0, 14) == 0) q.push_back({3'($urandom), 3'($urandom), 1'b0});
            q.push_back({6'b000000, 1'($urandom_range(0, 3) == 0)});
        end
        for (int i = 0; i < q.size(); i++) begin
            cyc(q[i][6:4], q[i][3:1], q[i][0]);
            n_vec++;
            if (dut_out !== model_out()) begin
                n_err++; $display("FAIL random cyc %0d in %b got %h expected %h", i, q[i], dut_out, model_out());
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) cyc(3'b001, 3'b000, 1'b0);
        cyc(3'b011, 3'b000, 1'b0);
        n_vec++;
        if (step !== 2'd2 || dir !== 2'b01) begin
            n_err++; $display("FAIL pre_reset got %b/%0d expected 01/2", dir, step);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (dut_out !== {16'h0, 7'b1111111}) begin
            n_err++; $display("FAIL reset_mid got %h expected %h", dut_out, {16'h0, 7'b1111111});
        end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        cyc(3'b000, 3'b100, 1'b0);
        n_vec++;
        if (dut_out !== model_out()) begin
            n_err++; $display("FAIL after_reset got %h expected %h", dut_out, model_out());
        end
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_right_cancel();
        test_skip();
        test_timing();
        test_conflicts();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
